// File: rtl/ntt_result_collector_pkg.sv
// Shared NTT constants: coefficient/address widths plus the collector's derived sizes.
package ntt_result_collector_pkg;
  localparam int COEF_W  = 60;
  localparam int LADDR_W = 9;

  function automatic int cores_f(input int log_cores);
    return 1 << log_cores;
  endfunction

  // The word index walks 2*CORES words, so it needs one bit more than the core index.
  function automatic int widx_w_f(input int log_cores);
    return log_cores + 1;
  endfunction

  function automatic int gaddr_w_f(input int log_cores);
    return LADDR_W + log_cores + 1;
  endfunction

  typedef enum logic {ST_IDLE, ST_DRAIN} col_state_e;
endpackage

// File: rtl/ntt_collector_bank.sv
// Capture bank for one full beat and the word-index mux that serializes it.
module ntt_collector_bank
  import ntt_result_collector_pkg::*;
#(
  parameter  int LOG_CORE_COUNT = 5,
  localparam int CORES   = cores_f(LOG_CORE_COUNT),
  localparam int WIDX_W  = widx_w_f(LOG_CORE_COUNT),
  localparam int GADDR_W = gaddr_w_f(LOG_CORE_COUNT)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load_i,
  input  logic [CORES-1:0][1:0][COEF_W-1:0]     in_data_i,
  input  logic [CORES-1:0][LADDR_W-1:0]         in_addr_i,
  input  logic [WIDX_W-1:0]                     widx_i,
  output logic [COEF_W-1:0]                     word_o,
  output logic [GADDR_W-1:0]                    gaddr_o
);
  logic [CORES-1:0][1:0][COEF_W-1:0] data_q;
  logic [CORES-1:0][LADDR_W-1:0]     addr_q;
  logic [LOG_CORE_COUNT-1:0]         core;
  logic                              half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      addr_q <= '0;
    end else if (load_i) begin
      data_q <= in_data_i;
      addr_q <= in_addr_i;
    end
  end

  assign core    = widx_i[WIDX_W-1:1];
  assign half    = widx_i[0];
  assign word_o  = data_q[core][half];
  assign gaddr_o = {addr_q[core], core, half};
endmodule

// File: rtl/ntt_result_collector.sv
// Serializes wide NTT core results into one word/address stream with frame markers.
module ntt_result_collector
  import ntt_result_collector_pkg::*;
#(
  parameter  int LOG_CORE_COUNT = 5,
  parameter  int FRAME_BEATS    = 16,
  localparam int CORES   = cores_f(LOG_CORE_COUNT),
  localparam int WIDX_W  = widx_w_f(LOG_CORE_COUNT),
  localparam int GADDR_W = gaddr_w_f(LOG_CORE_COUNT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CORES-1:0][1:0][COEF_W-1:0] in_data,
  input  logic [CORES-1:0][LADDR_W-1:0]     in_addr,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [COEF_W-1:0]                 m_data,
  output logic [GADDR_W-1:0]                m_addr,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              m_last,
  output logic                              frame_done
);
  localparam int BCNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [WIDX_W-1:0] WMAX = WIDX_W'(2 * CORES - 1);
  localparam logic [BCNT_W-1:0] BMAX = BCNT_W'(FRAME_BEATS - 1);

  col_state_e        state_q;
  logic [WIDX_W-1:0] w_q;
  logic [BCNT_W-1:0] beat_q;
  logic              frame_done_q;
  logic              last_word, m_hs;

  assign last_word  = (w_q == WMAX);
  assign m_valid    = (state_q == ST_DRAIN);
  assign m_hs       = m_valid && m_ready;
  assign m_last     = m_valid && last_word && (beat_q == BMAX);
  // Reloading on the last-word handshake lets back-to-back beats stream without a bubble.
  assign in_ready   = (state_q == ST_IDLE) || (last_word && m_ready);
  assign frame_done = frame_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      w_q          <= '0;
      beat_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= m_hs && m_last;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= ST_DRAIN;
            w_q     <= '0;
          end
        end
        ST_DRAIN: begin
          if (m_ready) begin
            if (last_word) begin
              beat_q <= (beat_q == BMAX) ? '0 : beat_q + 1'b1;
              w_q    <= '0;
              if (!in_valid) state_q <= ST_IDLE;
            end else begin
              w_q <= w_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ntt_collector_bank #(.LOG_CORE_COUNT(LOG_CORE_COUNT)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .load_i    (in_valid && in_ready),
    .in_data_i (in_data),
    .in_addr_i (in_addr),
    .widx_i    (w_q),
    .word_o    (m_data),
    .gaddr_o   (m_addr)
  );
endmodule

// File: tb/tb_ntt_result_collector.sv
// Scoreboard bench: accepted beats push 64 expected words; a negedge monitor checks every cycle.
module tb_ntt_result_collector;
  localparam int LOG = 5;
  localparam int CORES = 1 << LOG;
  localparam int FB = 16;
  localparam int NW = 2 * CORES;

  typedef struct packed {
    logic [59:0] d;
    logic [14:0] a;
    logic        l;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [CORES-1:0][1:0][59:0] in_data;
  logic [CORES-1:0][8:0]       in_addr;
  logic                        in_valid, in_ready;
  logic [59:0]                 m_data;
  logic [14:0]                 m_addr;
  logic                        m_valid, m_ready, m_last, frame_done;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   beat_m = 0;
  logic exp_fd = 1'b0;

  ntt_result_collector #(.LOG_CORE_COUNT(LOG), .FRAME_BEATS(FB)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_addr(in_addr), .in_valid(in_valid),
    .in_ready(in_ready), .m_data(m_data), .m_addr(m_addr), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      beat_m = 0;
      exp_fd = 1'b0;
    end else begin
      chk("m_valid", 64'(m_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(in_ready), 64'((sb.size() == 0) || (sb.size() == 1 && m_ready)));
      chk("frame_done", 64'(frame_done), 64'(exp_fd));
      exp_fd = 1'b0;
      if (m_valid) begin
        if (sb.size() == 0) chk("extra_word", 64'(m_valid), 64'(0));
        else begin
          e = sb[0];
          chk("m_data", 64'(m_data), 64'(e.d));
          chk("m_addr", 64'(m_addr), 64'(e.a));
          chk("m_last", 64'(m_last), 64'(e.l));
          if (m_ready) begin
            if (e.l) exp_fd = 1'b1;
            void'(sb.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        for (int w = 0; w < NW; w++) begin
          e.d = in_data[w >> 1][w & 1];
          e.a = {in_addr[w >> 1], 5'(w >> 1), 1'(w & 1)};
          e.l = (w == NW - 1) && (beat_m == FB - 1);
          sb.push_back(e);
        end
        beat_m = (beat_m + 1) % FB;
      end
    end
  end

  task automatic set_beat(input int tag);
    for (int k = 0; k < CORES; k++) begin
      for (int j = 0; j < 2; j++) in_data[k][j] = {16'(tag), 16'(k), 4'(j), 24'hA5C3E1};
      in_addr[k] = 9'(tag * 7 + k * 13);
    end
  endtask

  task automatic send_beat(input int tag);
    int n;
    set_beat(tag);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 2000);
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 64'(sb.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_m_addr", 64'(m_addr), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    m_ready = 1'b1;
    set_beat(0);
    #1 chk_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));

    // single beat; in_valid held with junk while busy must be ignored
    send_beat(1);
    set_beat(999);
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_drain();

    // backpressure: m_ready toggles every cycle
    send_beat(2);
    for (int i = 0; i < 140; i++) begin
      @(posedge clk);
      #1 m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    wait_drain();

    // back-to-back: beat 16 closes the frame, beat 17 opens the next
    for (int b = 3; b <= 17; b++) send_beat(b);
    wait_drain();

    // reset during word 20 of a beat, then a full fresh frame
    send_beat(20);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int b = 21; b <= 36; b++) send_beat(b);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ntt_result_collector.md
NTT_RESULT_COLLECTOR -- requirements
Module: ntt_result_collector

Interface
REQ-001 Parameter LOG_CORE_COUNT, default 5, log2 of the number of NTT cores feeding the block (CORES = 1 << LOG_CORE_COUNT).
REQ-002 Parameter FRAME_BEATS, default 16, number of accepted input beats per NTT frame; SHALL be at least 1.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port in_data, input, [59:0] x [CORES-1:0][1:0], result words from the processor; index [k][j] is core k, output j.
REQ-006 Port in_addr, input, [8:0] x [CORES-1:0], per-core local write address accompanying in_data.
REQ-007 Port in_valid, input, 1, the in_data/in_addr beat is valid.
REQ-008 Port in_ready, output, 1, the collector accepts a beat this cycle.
REQ-009 Port m_data, output, 60, serialized result word.
REQ-010 Port m_addr, output, LOG_CORE_COUNT+10, global address {local addr, core index k, half j}.
REQ-011 Port m_valid, output, 1, m_data/m_addr/m_last valid.
REQ-012 Port m_ready, input, 1, downstream accepts the word.
REQ-013 Port m_last, output, 1, high on the final word of a frame.
REQ-014 Port frame_done, output, 1, one-cycle pulse after the final word of a frame is accepted.

Function
REQ-015 A beat SHALL be accepted in any cycle where in_valid && in_ready; all 2*CORES words and CORES addresses are latched into a capture bank.
REQ-016 FSM states: IDLE (bank empty, in_ready=1, m_valid=0) and DRAIN (bank full, m_valid=1).
REQ-017 IDLE -> DRAIN on an accepted beat; the word index resets to 0.
REQ-018 In DRAIN, word index w (0..2*CORES-1) SHALL select core k = w>>1 and half j = w&1; m_data = bank[k][j], m_addr = {addr[k], k, j}.
REQ-019 The word index SHALL advance only on m_valid && m_ready; m_data/m_addr/m_last SHALL remain stable while m_valid && !m_ready.
REQ-020 in_ready SHALL equal IDLE || (DRAIN && w == 2*CORES-1 && m_ready), so a new beat overwrites the bank in the cycle the last word is accepted, and back-to-back beats stream without a bubble.
REQ-021 On the last-word handshake with no new beat accepted: DRAIN -> IDLE; with a new beat accepted: remain in DRAIN, w = 0.
REQ-022 A beat counter (0..FRAME_BEATS-1) SHALL increment when the last word of a beat is accepted and wrap to 0 after FRAME_BEATS-1.
REQ-023 m_last SHALL be high exactly while w == 2*CORES-1 and the beat counter == FRAME_BEATS-1.
REQ-024 frame_done SHALL pulse high for exactly the one cycle after the m_last word is accepted.
REQ-025 Latency: the first word of a beat SHALL appear on m_* in the cycle after acceptance; with m_ready held high a beat drains in 2*CORES cycles.
REQ-026 in_valid while !in_ready SHALL be ignored; no data is lost or altered in the bank.

Reset
REQ-027 rst SHALL asynchronously force IDLE, w = 0, beat counter = 0, m_valid = 0, m_last = 0, frame_done = 0, m_data = 0, m_addr = 0; in_ready = 1 after reset release.
REQ-028 Reset mid-DRAIN SHALL discard the partial beat and frame; the next accepted beat starts frame word 0.

Structure
REQ-029 CORES, the word-index width and the global address width SHALL be derived in the shared NTT package alongside the existing coefficient-width constants.
REQ-030 One sub-module, ntt_collector_bank (capture registers plus word mux), is natural; the FSM and counters stay in the top module.

Verification
REQ-031 Single beat, m_ready=1: words appear on 64 consecutive cycles starting 1 cycle after acceptance; word 5 is core 2, half 1, with m_addr = {addr[2], 5'd2, 1'b1}.
REQ-032 Backpressure: m_ready toggling 1/0 -> every word is held stable while stalled, no duplicates, 128 cycles per beat.
REQ-033 Back-to-back: in_valid held high, m_ready=1 -> the next beat is accepted on the last-word cycle and there is no idle cycle on m_valid.
REQ-034 FRAME_BEATS=16: m_last only on word 63 of beat 16; frame_done pulses once; beat 17 starts a new frame.
REQ-035 Assert rst during word 20 -> m_valid=0 immediately; the next beat streams from word 0 and m_last is counted from beat 1.
